// File: rtl/keypad_entry_pkg.sv
// Shared keypad constants, scan result
// and debounce state types.
package keypad_entry_pkg;

  localparam logic [3:0] KEY_BKSP  = 4'hE;
  localparam logic [3:0] KEY_ENTER = 4'hF;
  localparam logic [3:0] KEY_CLR   = 4'hA;
  localparam logic [3:0] COL_INIT  = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_HELD,
    ST_RELEASE
  } deb_state_e;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_ONE,
    RES_MULTI
  } scan_res_e;

  function automatic logic [3:0] key_decode(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] k;
    unique case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = KEY_BKSP;
      4'hD: k = 4'h0;
      4'hE: k = KEY_ENTER;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_entry_scan.sv
// Column strobing, row sampling, debounce
// and decode of a single key per press.
module keypad_scan
  import keypad_entry_pkg::*;
#(
  parameter int SCAN_DIV  = 50_000,
  parameter int DEB_SCANS = 5
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEB_SCANS + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE  = CW'(DEB_SCANS);

  logic [3:0]    row_s1_q, row_s2_q;
  logic [SW-1:0] slot_q, slot_d;
  logic [3:0]    col_q, col_d;
  logic          hit_q, hit_d;
  logic          multi_q, multi_d;
  logic [1:0]    hit_r_q, hit_r_d;
  logic [1:0]    hit_c_q, hit_c_d;

  logic          slot_end, scan_done;
  logic [3:0]    low;
  logic [2:0]    nlow;
  logic [1:0]    low_r, col_idx;
  logic          s_hit, s_multi;
  logic [1:0]    s_r, s_c;
  scan_res_e     res;
  logic [3:0]    res_key;

  deb_state_e    state_q;
  logic [CW-1:0] cnt_q, cnt_inc;
  logic [3:0]    cand_q, key_code_q;
  logic          key_valid_q;

  assign key_col   = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign cnt_inc   = cnt_q + CW'(1);

  // Bring the asynchronous rows into the clock domain
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      row_s1_q <= '1;
      row_s2_q <= '1;
    end else begin
      row_s1_q <= key_row;
      row_s2_q <= row_s1_q;
    end
  end

  // Slot timing, column rotation and per-scan hit accumulation
  always_comb begin
    low     = ~row_s2_q;
    nlow    = '0;
    low_r   = '0;
    col_idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (low[i]) low_r = 2'(i);
      if (!col_q[i]) col_idx = 2'(i);
      nlow = nlow + {2'b00, low[i]};
    end
    slot_end  = (slot_q == SLOT_LAST);
    scan_done = slot_end && (col_q == 4'b0111);
    s_hit     = hit_q;
    s_multi   = multi_q;
    s_r       = hit_r_q;
    s_c       = hit_c_q;
    if (slot_end) begin
      if (nlow > 3'd1 || (nlow == 3'd1 && hit_q)) begin
        s_multi = 1'b1;
      end else if (nlow == 3'd1) begin
        s_hit = 1'b1;
        s_r   = low_r;
        s_c   = col_idx;
      end
    end
    res = s_multi ? RES_MULTI :
          (s_hit ? RES_ONE : RES_NONE);
    res_key = key_decode(s_r, s_c);
    slot_d  = slot_end ? '0 : slot_q + SW'(1);
    col_d   = slot_end ? {col_q[2:0], col_q[3]} : col_q;
    hit_d   = scan_done ? 1'b0 : s_hit;
    multi_d = scan_done ? 1'b0 : s_multi;
    hit_r_d = scan_done ? 2'b00 : s_r;
    hit_c_d = scan_done ? 2'b00 : s_c;
  end

  // Scan state registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      slot_q  <= '0;
      col_q   <= COL_INIT;
      hit_q   <= 1'b0;
      multi_q <= 1'b0;
      hit_r_q <= '0;
      hit_c_q <= '0;
    end else begin
      slot_q  <= slot_d;
      col_q   <= col_d;
      hit_q   <= hit_d;
      multi_q <= multi_d;
      hit_r_q <= hit_r_d;
      hit_c_q <= hit_c_d;
    end
  end

  // Debounce FSM, stepped once per completed scan
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (scan_done) begin
        unique case (state_q)
          ST_IDLE: begin
            if (res == RES_ONE) begin
              state_q <= ST_PRESS;
              cnt_q   <= CW'(1);
              cand_q  <= res_key;
            end
          end
          ST_PRESS: begin
            if (res == RES_ONE && res_key == cand_q) begin
              cnt_q <= cnt_inc;
              if (cnt_inc == CNT_DONE) begin
                state_q     <= ST_HELD;
                key_code_q  <= cand_q;
                key_valid_q <= 1'b1;
              end
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_HELD: begin
            if (res != RES_ONE) begin
              state_q <= ST_RELEASE;
              cnt_q   <= CW'(1);
            end
          end
          default: begin
            if (res == RES_ONE) begin
              state_q <= ST_HELD;
            end else begin
              cnt_q <= cnt_inc;
              if (cnt_inc == CNT_DONE) state_q <= ST_IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: scanned key stream
// folded into a decimal entry and value.
module keypad_entry
  import keypad_entry_pkg::*;
#(
  parameter int SCAN_DIV  = 50_000,
  parameter int DEB_SCANS = 5
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [3:0]  key_row,
  output logic [3:0]  key_col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [15:0] entry,
  output logic [15:0] value,
  output logic        value_valid
);

  logic [15:0] entry_q, entry_d;
  logic [15:0] value_q, value_d;
  logic        vv_q, vv_d;
  logic [19:0] ext;

  keypad_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .DEB_SCANS (DEB_SCANS)
  ) u_scan (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_row   (key_row),
    .key_col   (key_col),
    .key_code  (key_code),
    .key_valid (key_valid)
  );

  assign entry       = entry_q;
  assign value       = value_q;
  assign value_valid = vv_q;

  // Apply an accepted key to the number being typed
  always_comb begin
    ext     = {4'b0000, entry_q} * 20'd10 + {16'h0000, key_code};
    entry_d = entry_q;
    value_d = value_q;
    vv_d    = 1'b0;
    if (key_valid) begin
      unique case (1'b1)
        (key_code <= 4'd9): begin
          if (ext <= 20'd65535) entry_d = ext[15:0];
        end
        (key_code == KEY_BKSP): entry_d = entry_q / 16'd10;
        (key_code == KEY_CLR):  entry_d = '0;
        (key_code == KEY_ENTER): begin
          value_d = entry_q;
          vv_d    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Entry and committed value registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      entry_q <= '0;
      value_q <= '0;
      vv_q    <= 1'b0;
    end else begin
      entry_q <= entry_d;
      value_q <= value_d;
      vv_q    <= vv_d;
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed plus random key sequences against
// an arithmetic model of the keypad entry.
module tb_keypad_entry;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [15:0] entry;
  logic [15:0] value;
  logic        value_valid;

  logic [15:0] pressed = '0;
  int n_vec = 0;
  int n_err = 0;
  int kv_cnt = 0;
  int vv_cnt = 0;
  int m_entry = 0;
  int m_value = 0;
  int m_vv = 0;
  logic [3:0] kmap [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };
  logic [3:0] col_seq [4] = '{
    4'b1101, 4'b1011, 4'b0111, 4'b1110
  };

  keypad_entry #(
    .SCAN_DIV  (4),
    .DEB_SCANS (2)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_row     (key_row),
    .key_col     (key_col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .entry       (entry),
    .value       (value),
    .value_valid (value_valid)
  );

  always #5 sys_clk = ~sys_clk;

  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
  end

  always @(posedge sys_clk) begin
    if (key_valid) kv_cnt <= kv_cnt + 1;
    if (value_valid) vv_cnt <= vv_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pos_of(input logic [3:0] k);
    for (int i = 0; i < 16; i++)
      if (kmap[i] == k) return i;
    return 0;
  endfunction

  function automatic void model_key(input logic [3:0] k);
    int t;
    if (k <= 4'd9) begin
      t = m_entry * 10 + int'(k);
      if (t <= 65535) m_entry = t;
    end else if (k == 4'hE) begin
      m_entry = m_entry / 10;
    end else if (k == 4'hA) begin
      m_entry = 0;
    end else if (k == 4'hF) begin
      m_value = m_entry;
      m_vv++;
    end
  endfunction

  task automatic align();
    int n = 0;
    while (key_col !== 4'b0111 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    while (key_col !== 4'b1110 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 200) chk("align_timeout", 32'(n), 32'd0);
  endtask

  task automatic hold(input logic [15:0] mask, input int scans);
    align();
    pressed = mask;
    repeat (scans * 16) @(negedge sys_clk);
    pressed = '0;
    repeat (48) @(negedge sys_clk);
  endtask

  task automatic type_key(input logic [3:0] k);
    int kv0 = kv_cnt;
    hold(16'(1) << pos_of(k), 3);
    model_key(k);
    chk("kv_count", 32'(kv_cnt), 32'(kv0 + 1));
    chk("key_code", 32'(key_code), 32'(k));
    chk("entry", 32'(entry), 32'(m_entry));
    chk("value", 32'(value), 32'(m_value));
    chk("vv_count", 32'(vv_cnt), 32'(m_vv));
  endtask

  initial begin
    int kv0;
    logic [3:0] k;
    logic [3:0] seq1 [6] = '{4'h6, 4'h5, 4'h5, 4'h3, 4'h5, 4'hF};
    logic [3:0] seq2 [5] = '{4'hA, 4'h1, 4'h2, 4'h3, 4'hE};

    repeat (3) @(negedge sys_clk);
    chk("rst_col", 32'(key_col), 32'h0E);
    chk("rst_code", 32'(key_code), 32'h0);
    chk("rst_kv", 32'(key_valid), 32'h0);
    chk("rst_entry", 32'(entry), 32'h0);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_vv", 32'(value_valid), 32'h0);
    sys_rst_n = 1'b1;
    chk("col0", 32'(key_col), 32'h0E);
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge sys_clk);
      chk("col_step", 32'(key_col), 32'(col_seq[i]));
    end

    type_key(4'h5);
    chk("entry5", 32'(entry), 32'd5);
    type_key(4'hA);

    foreach (seq1[i]) type_key(seq1[i]);
    chk("value_max", 32'(value), 32'd65535);
    type_key(4'h0);
    chk("entry_sat", 32'(entry), 32'd65535);

    foreach (seq2[i]) type_key(seq2[i]);
    chk("entry12", 32'(entry), 32'd12);
    type_key(4'hA);
    chk("entry_clr", 32'(entry), 32'd0);
    chk("value_kept", 32'(value), 32'd65535);

    kv0 = kv_cnt;
    hold(16'b0000_0000_0000_0011, 4);
    chk("multi_none", 32'(kv_cnt), 32'(kv0));
    type_key(4'h8);

    repeat (12) begin
      k = 4'($urandom_range(0, 15));
      type_key(k);
    end

    kv0 = kv_cnt;
    align();
    for (int i = 0; i < 5; i++) begin
      pressed = (i % 2 == 0) ? 16'(1) << pos_of(4'h9) : 16'h0;
      repeat (16) @(negedge sys_clk);
    end
    pressed = '0;
    repeat (48) @(negedge sys_clk);
    chk("bounce_none", 32'(kv_cnt), 32'(kv0));

    align();
    pressed = 16'(1) << pos_of(4'h1);
    repeat (20) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    pressed = '0;
    @(negedge sys_clk);
    m_entry = 0;
    m_value = 0;
    chk("mid_kv", 32'(kv_cnt), 32'(kv0));
    chk("mid_col", 32'(key_col), 32'h0E);
    chk("mid_code", 32'(key_code), 32'h0);
    chk("mid_entry", 32'(entry), 32'h0);
    chk("mid_value", 32'(value), 32'h0);
    chk("mid_vv", 32'(value_valid), 32'h0);
    sys_rst_n = 1'b1;
    type_key(4'h7);
    chk("post_rst", 32'(entry), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
